// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Issues credit-limited read requests to a fixed-latency FIFO
//               and re-presents the returned words as a show-ahead
//               ready/valid stream through a small skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int WIDTH          = 20,
  parameter int READ_LATENCY   = 2,
  parameter int BUF_DEPTH_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      fifoReadRequest,
  input  logic [WIDTH-1:0]          fifoDataIn,
  input  logic                      fifoDataValid,
  output logic [WIDTH-1:0]          dataOut,
  output logic                      dataOutValid,
  input  logic                      dataOutReady,
  output logic [BUF_DEPTH_LOG2:0]   bufUsed,
  output logic                      protocolError
);

  localparam int c_CAP  = 1 << BUF_DEPTH_LOG2;
  localparam int c_IFW  = $clog2(READ_LATENCY + 1) + 1;
  localparam int c_BUW  = BUF_DEPTH_LOG2 + 1;
  localparam int c_SUMW = ((c_IFW > c_BUW) ? c_IFW : c_BUW) + 1;

  logic               r_rstHeld;
  logic [c_IFW-1:0]   r_inFlight;
  logic [c_IFW-1:0]   r_ignoreCnt;
  logic               w_expectValid;
  logic               w_ignore;
  logic               w_pop;
  logic               w_full;
  logic               w_write;
  logic               w_overflow;
  logic               w_unexpected;
  logic [c_SUMW-1:0]  w_committed;

  // Credit covers every slot that may still land in the buffer, so a request
  // is only raised when the buffer is guaranteed room for its reply.
  always_comb begin
    w_pop           = dataOutValid && dataOutReady;
    w_committed     = c_SUMW'(r_inFlight) + c_SUMW'(bufUsed);
    fifoReadRequest = !r_rstHeld && (w_committed < (c_SUMW'(c_CAP) + c_SUMW'(w_pop)));
  end

  always_comb begin
    dataOutValid = (bufUsed != '0);
    w_ignore     = (r_ignoreCnt != '0);
    w_full       = (bufUsed == c_BUW'(c_CAP));
    w_unexpected = fifoDataValid && !w_ignore && !w_expectValid;
    w_overflow   = fifoDataValid && !w_ignore && w_expectValid && w_full && !w_pop;
    w_write      = fifoDataValid && !w_ignore && w_expectValid && !(w_full && !w_pop);
  end

  // Replies to requests made before a reset can still arrive for up to
  // READ_LATENCY cycles after release; that window is silently dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstHeld     <= 1'b1;
      r_ignoreCnt   <= c_IFW'(READ_LATENCY);
      r_inFlight    <= '0;
      bufUsed       <= '0;
      protocolError <= 1'b0;
    end else begin
      r_rstHeld <= 1'b0;
      if (w_ignore) begin
        r_ignoreCnt <= r_ignoreCnt - 1'b1;
      end
      case ({fifoReadRequest, w_expectValid})
        2'b10:   r_inFlight <= r_inFlight + 1'b1;
        2'b01:   r_inFlight <= r_inFlight - 1'b1;
        default: r_inFlight <= r_inFlight;
      endcase
      if (w_write && !w_pop) begin
        bufUsed <= bufUsed + 1'b1;
      end else if (!w_write && w_pop) begin
        bufUsed <= bufUsed - 1'b1;
      end
      if (w_unexpected || w_overflow) begin
        protocolError <= 1'b1;
      end
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_noPipe
      assign w_expectValid = fifoReadRequest;
    end else begin : g_pipe
      logic [READ_LATENCY-1:0] r_reqPipe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_reqPipe <= '0;
        end else begin
          r_reqPipe[0] <= fifoReadRequest;
          for (int i = 1; i < READ_LATENCY; i++) begin
            r_reqPipe[i] <= r_reqPipe[i-1];
          end
        end
      end

      assign w_expectValid = r_reqPipe[READ_LATENCY-1];
    end
  endgenerate

  generate
    if (BUF_DEPTH_LOG2 == 0) begin : g_single
      logic [WIDTH-1:0] r_entry;

      always_ff @(posedge clk) begin
        if (w_write) begin
          r_entry <= fifoDataIn;
        end
      end

      assign dataOut = r_entry;
    end else begin : g_ring
      logic [WIDTH-1:0]          r_mem [c_CAP];
      logic [BUF_DEPTH_LOG2-1:0] r_wrPtr;
      logic [BUF_DEPTH_LOG2-1:0] r_rdPtr;

      // Pointers wrap naturally because the ring size is a power of two.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wrPtr <= '0;
          r_rdPtr <= '0;
        end else begin
          if (w_write) begin
            r_wrPtr <= r_wrPtr + 1'b1;
          end
          if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (w_write) begin
          r_mem[r_wrPtr] <= fifoDataIn;
        end
      end

      assign dataOut = r_mem[r_rdPtr];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Randomized self-checking bench for fifo_stream_reader, using
//               a queue-based FIFO and stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  localparam int W    = 20;
  localparam int LA   = 2;
  localparam int CAPA = 4;

  typedef struct packed {
    logic         v;
    logic         live;
    logic [W-1:0] d;
  } resp_t;

  logic         clk;
  logic         rst;
  logic         aReq, aDv, aDov, aRdy, aErr;
  logic [W-1:0] aDin, aDout;
  logic [2:0]   aUsed;
  logic         bReq, bDv, bDov, bRdy, bErr;
  logic [W-1:0] bDin, bDout;
  logic [0:0]   bUsed;

  fifo_stream_reader #(.WIDTH(W), .READ_LATENCY(LA), .BUF_DEPTH_LOG2(2)) dutA (
    .clk(clk), .rst(rst), .fifoReadRequest(aReq), .fifoDataIn(aDin),
    .fifoDataValid(aDv), .dataOut(aDout), .dataOutValid(aDov),
    .dataOutReady(aRdy), .bufUsed(aUsed), .protocolError(aErr)
  );

  fifo_stream_reader #(.WIDTH(W), .READ_LATENCY(0), .BUF_DEPTH_LOG2(0)) dutB (
    .clk(clk), .rst(rst), .fifoReadRequest(bReq), .fifoDataIn(bDin),
    .fifoDataValid(bDv), .dataOut(bDout), .dataOutValid(bDov),
    .dataOutReady(bRdy), .bufUsed(bUsed), .protocolError(bErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO contents, reply pipe and expected stream contents
  logic [W-1:0] aQ[$], expA[$], bQ[$], expB[$];
  resp_t        aPipe[$];
  bit           aHist[$];
  int           aCyc, bCyc;
  bit           aErrExp, aSpur;
  int           checks, errors;
  int           aDelivered, aFirstDov, aFirstPop, aLastPop, aMaxUsed, bPops;
  logic [W-1:0] aPrevDout;
  bit           aPrevStall;

  function automatic int outstanding();
    int s = 0;
    foreach (aHist[i]) s += int'(aHist[i]);
    return s;
  endfunction

  task automatic reset_models();
    resp_t z;
    z = '0;
    expA.delete(); expB.delete(); aPipe.delete(); aHist.delete();
    for (int i = 0; i < LA; i++) begin
      aPipe.push_back(z);
      aHist.push_back(1'b0);
    end
    aCyc = 0; bCyc = 0; aErrExp = 0; aSpur = 0; aPrevStall = 0;
    aDelivered = 0; aFirstDov = -1; aFirstPop = -1; aLastPop = -1; aMaxUsed = 0; bPops = 0;
  endtask

  // One clock cycle: drive FIFO replies at the falling edge, check, advance.
  task automatic step();
    resp_t        h, n;
    int           os;
    bit           aPop, bPop, aCredit, bCredit;
    logic [W-1:0] bWord;
    h    = aPipe[0];
    aDv  = h.v | aSpur;
    aDin = h.v ? h.d : W'($urandom);
    #1;
    bDv   = bReq && (bQ.size() != 0);
    bWord = (bQ.size() != 0) ? bQ[0] : '0;
    bDin  = bDv ? bWord : W'($urandom);
    #1;
    aPop    = (expA.size() != 0) && aRdy;
    os      = outstanding();
    aCredit = (aCyc != 0) && (os + expA.size() - int'(aPop) < CAPA);
    checks++;
    if (aUsed !== 3'(expA.size())) begin
      errors++; $display("FAIL a_bufUsed cyc=%0d got=%0d exp=%0d", aCyc, aUsed, expA.size());
    end
    checks++;
    if (aDov !== (expA.size() != 0)) begin
      errors++; $display("FAIL a_valid cyc=%0d got=%b exp=%b", aCyc, aDov, expA.size() != 0);
    end
    if (expA.size() != 0) begin
      checks++;
      if (aDout !== expA[0]) begin
        errors++; $display("FAIL a_data cyc=%0d got=%h exp=%h", aCyc, aDout, expA[0]);
      end
    end
    if (aPrevStall && aDov) begin
      checks++;
      if (aDout !== aPrevDout) begin
        errors++; $display("FAIL a_hold cyc=%0d got=%h exp=%h", aCyc, aDout, aPrevDout);
      end
    end
    checks++;
    if (aReq !== aCredit) begin
      errors++; $display("FAIL a_request cyc=%0d got=%b exp=%b", aCyc, aReq, aCredit);
    end
    checks++;
    if (aErr !== aErrExp) begin
      errors++; $display("FAIL a_protocolError cyc=%0d got=%b exp=%b", aCyc, aErr, aErrExp);
    end
    bPop    = (expB.size() != 0) && bRdy;
    bCredit = (bCyc != 0) && (expB.size() - int'(bPop) < 1);
    checks++;
    if (bUsed !== 1'(expB.size()) || bDov !== (expB.size() != 0)) begin
      errors++; $display("FAIL b_occupancy cyc=%0d got=%0d/%b exp=%0d", bCyc, bUsed, bDov, expB.size());
    end
    if (expB.size() != 0) begin
      checks++;
      if (bDout !== expB[0]) begin
        errors++; $display("FAIL b_data cyc=%0d got=%h exp=%h", bCyc, bDout, expB[0]);
      end
    end
    checks++;
    if (bReq !== bCredit || bErr !== 1'b0) begin
      errors++; $display("FAIL b_request cyc=%0d got=%b/%b exp=%b/0", bCyc, bReq, bErr, bCredit);
    end
    if (aDov && aFirstDov < 0) aFirstDov = aCyc;
    if (aDov && aRdy) begin
      aDelivered++;
      if (aFirstPop < 0) aFirstPop = aCyc;
      aLastPop = aCyc;
    end
    if (int'(aUsed) > aMaxUsed) aMaxUsed = int'(aUsed);
    aPrevStall = aDov && !aRdy;
    aPrevDout  = aDout;
    if (aPop) expA.delete(0);
    if (h.v && h.live) expA.push_back(h.d);
    if (aSpur) aErrExp = 1'b1;
    aPipe.delete(0);
    n = '0;
    if (aReq && aQ.size() != 0) begin
      n.v = 1'b1; n.live = 1'b1; n.d = aQ[0];
      aQ.delete(0);
    end
    aPipe.push_back(n);
    aHist.delete(0);
    aHist.push_back(aReq);
    if (bPop) expB.delete(0);
    if (bDv) begin
      expB.push_back(bWord);
      bQ.delete(0);
    end
    if (bDov && bRdy) bPops++;
    @(posedge clk);
    @(negedge clk);
    aCyc++; bCyc++;
  endtask

  task automatic check_cleared(input string tag);
    checks++;
    if (aReq !== 1'b0 || aDov !== 1'b0 || aUsed !== 3'd0 || aErr !== 1'b0 ||
        bReq !== 1'b0 || bDov !== 1'b0 || bUsed !== 1'b0 || bErr !== 1'b0) begin
      errors++;
      $display("FAIL %s got=req%b val%b used%0d err%b/req%b val%b used%0d err%b exp=all0",
               tag, aReq, aDov, aUsed, aErr, bReq, bDov, bUsed, bErr);
    end
  endtask

  task automatic do_reset();
    aDv = 0; bDv = 0; aSpur = 0;
    rst = 1'b1;
    #1;
    check_cleared("reset_state");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_models();
  endtask

  task automatic test_reset();
    aQ.delete(); bQ.delete(); aRdy = 1; bRdy = 0;
    do_reset();
    repeat (3) step();
  endtask

  task automatic test_steady_stream();
    aQ.delete(); bQ.delete(); aRdy = 1; bRdy = 0;
    do_reset();
    for (int i = 1; i <= 16; i++) aQ.push_back(W'(i));
    repeat (24) step();
    checks++;
    if (aFirstDov !== 4 || aFirstPop !== 4 || aLastPop !== 19 || aDelivered !== 16) begin
      errors++;
      $display("FAIL steady_throughput got=first%0d pop%0d..%0d n%0d exp=first4 pop4..19 n16",
               aFirstDov, aFirstPop, aLastPop, aDelivered);
    end
  endtask

  task automatic test_backpressure();
    aQ.delete(); bQ.delete(); bRdy = 0;
    do_reset();
    for (int i = 1; i <= 16; i++) aQ.push_back(W'(i));
    for (int c = 0; c < 45; c++) begin
      aRdy = (c < 5 || c >= 15);
      step();
    end
    checks++;
    if (aMaxUsed !== CAPA || aDelivered !== 16) begin
      errors++; $display("FAIL backpressure got=max%0d n%0d exp=max%0d n16", aMaxUsed, aDelivered, CAPA);
    end
  endtask

  task automatic test_empty_fifo();
    aQ.delete(); bQ.delete(); aRdy = 1; bRdy = 0;
    do_reset();
    repeat (20) step();
    aQ.push_back(20'hABC);
    repeat (LA + 3) step();
    checks++;
    if (aFirstDov < 21 || aFirstDov > 20 + LA + 2 || aDelivered !== 1) begin
      errors++; $display("FAIL empty_then_push got=firstValid%0d n%0d exp=21..%0d n1", aFirstDov, aDelivered, 20 + LA + 2);
    end
  endtask

  task automatic test_latency0();
    aQ.delete(); bQ.delete(); aRdy = 0; bRdy = 0;
    do_reset();
    for (int i = 1; i <= 12; i++) bQ.push_back(W'(i));
    for (int c = 0; c < 26; c++) begin
      bRdy = (c >= 2) && (c % 2 == 0);
      step();
    end
    checks++;
    if (bPops !== 12) begin
      errors++; $display("FAIL latency0_pops got=%0d exp=12", bPops);
    end
  endtask

  task automatic test_random();
    aQ.delete(); bQ.delete();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      aRdy = ($urandom_range(0, 3) != 0) ^ (c >= 150 && $urandom_range(0, 1) == 1);
      bRdy = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 2) != 0 && aQ.size() < 8) aQ.push_back(W'($urandom));
      if ($urandom_range(0, 2) == 0 && bQ.size() < 4) bQ.push_back(W'($urandom));
      step();
    end
  endtask

  task automatic test_reset_midstream();
    resp_t s;
    aQ.delete(); bQ.delete(); bRdy = 0;
    do_reset();
    for (int i = 0; i < 40; i++) aQ.push_back(W'($urandom));
    for (int c = 0; c < 60; c++) begin
      if (aCyc > 4 && expA.size() >= 2 && outstanding() >= 1 &&
          expA.size() + outstanding() == CAPA) break;
      aRdy = $urandom_range(0, 1) == 1;
      step();
    end
    aRdy = 0;
    aDv = aPipe[0].v;
    aDin = aPipe[0].d;
    #2;
    rst = 1'b1;
    #1;
    check_cleared("midstream_async_clear");
    aDv = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_models();
    for (int i = 0; i < LA; i++) begin
      s.v = 1'b1; s.live = 1'b0; s.d = W'($urandom);
      aPipe[i] = s;
    end
    aRdy = 1;
    repeat (14) step();
    checks++;
    if (aErr !== 1'b0 || aDelivered < 5) begin
      errors++; $display("FAIL midstream_recovery got=err%b n%0d exp=err0 n>=5", aErr, aDelivered);
    end
  endtask

  task automatic test_spurious();
    aQ.delete(); bQ.delete(); bRdy = 0; aRdy = 0;
    do_reset();
    for (int i = 0; i < 20; i++) aQ.push_back(W'($urandom));
    for (int c = 0; c < 30; c++) begin
      if (expA.size() == CAPA && outstanding() == 0) break;
      step();
    end
    aSpur = 1;
    step();
    aSpur = 0;
    aRdy = 1;
    repeat (8) step();
    checks++;
    if (aErr !== 1'b1) begin
      errors++; $display("FAIL spurious_sticky got=%b exp=1", aErr);
    end
    do_reset();
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    aRdy = 0; bRdy = 0; aDv = 0; bDv = 0; aDin = '0; bDin = '0; aSpur = 0;
    reset_models();
    @(negedge clk);
    test_reset();
    test_steady_stream();
    test_backpressure();
    test_empty_fifo();
    test_latency0();
    test_reset_midstream();
    test_spurious();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
